// File: rtl/medidor_pkg.sv
// Shared constants and FSM encoding for the tone-frequency meter.
package medidor_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned MIN_FREQ   = 20;
  localparam int unsigned MAX_PERIOD = CLK_HZ / MIN_FREQ;
  localparam int unsigned W          = 32;

  typedef enum logic {
    ARM,
    COUNT
  } estado_t;

endpackage

// File: rtl/divisor_secuencial.sv
// Restoring divider, one quotient bit per cycle; quotient truncated to OUT_W bits.
// Latency WIDTH+1 cycles from start (load + WIDTH iterations); done_o marks the final iteration.
module divisor_secuencial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] quotient_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [OUT_W-2:0] quo_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic             last;

  // The partial remainder never reaches 2*divisor, so the borrow bit of diff is the quotient bit.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[WIDTH];
    rem_d  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    last   = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  assign busy_o     = busy_q;
  assign done_o     = last;
  assign quotient_o = {quo_q, qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      quo_q <= {quo_q[OUT_W-3:0], qbit};
      cnt_q <= cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      dvd_q  <= dividend_i;
      dvs_q  <= divisor_i;
      rem_q  <= '0;
      quo_q  <= '0;
    end
  end

endmodule

// File: rtl/medidor_frecuencia.sv
// Tone-frequency meter: freq = CLK_HZ/period, freq_valid at E+W+2 after the registered edge E.
// MEDIDOR_PROMEDIO_EN: averages 4 periods per result ((4*CLK_HZ)/sum, one extra cycle per extra divider bit).
module medidor_frecuencia #(
  parameter int unsigned CLK_HZ   = medidor_pkg::CLK_HZ,
  parameter int unsigned MIN_FREQ = medidor_pkg::MIN_FREQ,
  parameter int unsigned W        = medidor_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tone_in,
  output logic [W-1:0] freq,
  output logic         freq_valid,
  output logic         no_signal,
  output logic         busy
);

  import medidor_pkg::*;

  localparam int unsigned MAX_P = CLK_HZ / MIN_FREQ;
`ifdef MEDIDOR_PROMEDIO_EN
  localparam int unsigned NAVG = 4;
  localparam int unsigned DW   = W + 2;
`else
  localparam int unsigned NAVG = 1;
  localparam int unsigned DW   = W;
`endif
  localparam logic [DW-1:0] DIVIDENDO = DW'(64'(CLK_HZ) * 64'(NAVG));

  logic          sync1_q, sync2_q, sync3_q, edge_q;
  estado_t       estado_q, estado_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0] acum_q, acum_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] suma;
  logic [1:0]    grp_q, grp_d;
  logic          start_q, start_d;
  logic [W-1:0]  freq_q, freq_d;
  logic          valid_q, valid_d;
  logic          nosig_q, nosig_d;
  logic          div_busy, div_done;
  logic [W-1:0]  div_quot;
  logic          ocupado, timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // A pending start counts as busy so an edge right after an accepted one is dropped.
  assign ocupado = div_busy | start_q;
  assign timeout = (estado_q == COUNT) && (cnt_q == W'(MAX_P - 2)) && !edge_q;

  always_ff @(posedge clk) begin
    if (!rst_n) estado_q <= ARM;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ARM:     if (edge_q) estado_d = COUNT;
      COUNT:   if (timeout) estado_d = ARM;
      default: estado_d = ARM;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    acum_d  = acum_q;
    grp_d   = grp_q;
    dvs_d   = dvs_q;
    start_d = 1'b0;
    freq_d  = freq_q;
    valid_d = 1'b0;
    nosig_d = nosig_q;
    suma    = acum_q + DW'(cnt_q) + DW'(1);
    if (estado_q == COUNT) begin
      if (edge_q) begin
        if (ocupado) begin
          acum_d = '0;
          grp_d  = '0;
        end else if (grp_q == 2'(NAVG - 1)) begin
          start_d = 1'b1;
          dvs_d   = suma;
          acum_d  = '0;
          grp_d   = '0;
        end else begin
          acum_d = suma;
          grp_d  = grp_q + 2'd1;
        end
      end else if (timeout) begin
        acum_d  = '0;
        grp_d   = '0;
        freq_d  = '0;
        nosig_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      acum_d = '0;
      grp_d  = '0;
    end
    if (div_done) begin
      freq_d  = div_quot;
      valid_d = 1'b1;
      nosig_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acum_q  <= '0;
      grp_q   <= '0;
      dvs_q   <= '0;
      start_q <= 1'b0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      nosig_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      acum_q  <= acum_d;
      grp_q   <= grp_d;
      dvs_q   <= dvs_d;
      start_q <= start_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      nosig_q <= nosig_d;
    end
  end

  divisor_secuencial #(
    .WIDTH (DW),
    .OUT_W (W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_q),
    .dividend_i (DIVIDENDO),
    .divisor_i  (dvs_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign no_signal  = nosig_q;
  assign busy       = div_busy;

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Randomised bench for medidor_frecuencia against an event-level reference model.
module tb_medidor_frecuencia;

  localparam int CLK  = 1_000_000;
  localparam int MINF = 250;
  localparam int MAXP = CLK / MINF;
`ifdef MEDIDOR_PROMEDIO_EN
  localparam int NAVG = 4;
  localparam int LAT  = 32 + 4;
`else
  localparam int NAVG = 1;
  localparam int LAT  = 32 + 2;
`endif
  // tone_in driven in cycle n shows up as the registered edge flag in cycle n+3
  localparam int SYNC_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [31:0] freq;
  logic        freq_valid;
  logic        no_signal;
  logic        busy;

  medidor_frecuencia #(
    .CLK_HZ   (CLK),
    .MIN_FREQ (MINF),
    .W        (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone_in    (tone_in),
    .freq       (freq),
    .freq_valid (freq_valid),
    .no_signal  (no_signal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // event kinds: 0 = freq_valid pulse, 1 = no_signal rises, 2 = no_signal falls
  typedef struct {
    int          c;
    int          k;
    logic [63:0] v;
  } ev_t;

  ev_t    exp_q[$];
  ev_t    got_q[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  int     busy_cnt = 0;
  bit     ns_prev = 1'b1;

  bit     m_armed = 1'b0;
  bit     m_nosig = 1'b1;
  int     m_last = 0;
  int     m_start = -100000;
  int     m_grp = 0;
  longint m_sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (freq_valid) got_q.push_back('{cyc, 0, 64'(freq)});
    if (no_signal && !ns_prev) got_q.push_back('{cyc, 1, 64'(freq)});
    if (!no_signal && ns_prev) got_q.push_back('{cyc, 2, 64'd0});
    if (no_signal === 1'b0 || no_signal === 1'b1) ns_prev = no_signal;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic void model_flush(input int n);
    if (m_armed && n >= m_last + MAXP) begin
      if (!m_nosig) exp_q.push_back('{m_last + MAXP, 1, 64'd0});
      m_nosig = 1'b1;
      m_armed = 1'b0;
      m_grp   = 0;
      m_sum   = 0;
    end
  endfunction

  function automatic void model_edge(input int n);
    int e, d;
    e = n + SYNC_LAT;
    model_flush(e);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_last  = e;
      return;
    end
    d      = e - m_last;
    m_last = e;
    if (e - m_start >= 1 && e - m_start <= LAT - 1) begin
      m_grp = 0;
      m_sum = 0;
      return;
    end
    m_sum += d;
    m_grp++;
    if (m_grp == NAVG) begin
      exp_q.push_back('{e + LAT, 0, 64'(32'((longint'(NAVG) * CLK) / m_sum))});
      if (m_nosig) exp_q.push_back('{e + LAT, 2, 64'd0});
      m_nosig = 1'b0;
      m_start = e;
      m_grp   = 0;
      m_sum   = 0;
    end
  endfunction

  // reset sampled at the end of cycle r: anything expected after r never happens
  function automatic void model_reset(input int r);
    bit ns;
    model_flush(r);
    ns = m_nosig;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].c > r) begin
      if (exp_q[exp_q.size()-1].k == 2) ns = 1'b1;
      if (exp_q[exp_q.size()-1].k == 1) ns = 1'b0;
      void'(exp_q.pop_back());
    end
    if (!ns) exp_q.push_back('{r + 1, 1, 64'd0});
    m_nosig = 1'b1;
    m_armed = 1'b0;
    m_start = -100000;
    m_grp   = 0;
    m_sum   = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic tone_cycle(input int p);
    int hi;
    hi = (p / 2 < 1) ? 1 : p / 2;
    tone_in = 1'b1;
    model_edge(cyc);
    repeat (hi) tick();
    tone_in = 1'b0;
    repeat (p - hi) tick();
  endtask

  task automatic check_events(input string tag);
    model_flush(cyc);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_cycle"}, 64'(got_q[i].c), 64'(exp_q[i].c));
      check({tag, "_kind"}, 64'(got_q[i].k), 64'(exp_q[i].k));
      check({tag, "_value"}, got_q[i].v, exp_q[i].v);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int b0;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tone_in = ~tone_in;
      tick();
    end
    rst_n   = 1'b1;
    tone_in = 1'b0;
    check("rst_freq", 64'(freq), 64'd0);
    check("rst_no_signal", 64'(no_signal), 64'd1);
    check("rst_freq_valid", 64'(freq_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    idle(20);
    check_events("reset");

    repeat (5) tone_cycle(1000);
    idle(60);
    check_events("tone_1k");
    check("lock_no_signal", 64'(no_signal), 64'd0);

    repeat (12) tone_cycle(int'($urandom_range(2000, 2)));
    idle(60);
    check_events("random");

    b0 = busy_cnt;
    repeat (30) tone_cycle(20);
    repeat (10) tone_cycle(2);
    repeat (10) tone_cycle(3);
    idle(60);
    check_events("fast");
    check("fast_busy_seen", 64'(busy_cnt > b0), 64'd1);

    // longest period that still measures, then a gap that just times out
    tone_cycle(1000);
    tone_cycle(MAXP - 1);
    tone_cycle(1000);
    tone_cycle(MAXP);
    tone_cycle(1000);
    tone_cycle(1000);
    idle(60);
    check_events("boundary");

    repeat (3) tone_cycle(1000);
    idle(MAXP + 100);
    check_events("timeout");
    check("timeout_no_signal", 64'(no_signal), 64'd1);
    check("timeout_freq", 64'(freq), 64'd0);
    repeat (3) tone_cycle(1000);
    idle(60);
    check_events("restart");

    tone_cycle(800);
    tone_in = 1'b1;
    model_edge(cyc);
    repeat (SYNC_LAT + 10) tick();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    model_reset(cyc);
    tick();
    rst_n = 1'b1;
    idle(100);
    check_events("mid_reset");
    check("mid_reset_freq", 64'(freq), 64'd0);
    check("mid_reset_no_signal", 64'(no_signal), 64'd1);
    check("mid_reset_busy", 64'(busy), 64'd0);

    repeat (6) tone_cycle(1000);
    idle(60);
    check_events("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
